norm_shift_16: RTL and testbench
================================

# norm_shift_16

Two-stage pipelined normalizer for 16-bit mantissas. It sits directly downstream of the 16-bit leading-zero counter (`lza_16`) in the FP datapath. It takes an unnormalized mantissa with a biased exponent and left-shifts the mantissa until its MSB is set. The exponent is decremented by the same amount, and the shift clamps at the exponent so results never go below the denormal range. Valid/ready handshakes on both sides give full throughput with back-pressure.

## Interface
- No parameters; widths are fixed (mantissa 16 bits, exponent 8 bits).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream presents an operand.
- `in_ready`  out  1  block can accept an operand this cycle.
- `in_mant`  in  16  unnormalized mantissa.
- `in_exp`  in  8  biased exponent, unsigned.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_mant`  out  16  normalized mantissa.
- `out_exp`  out  8  adjusted exponent.
- `out_zero`  out  1  input mantissa was zero (only with `NORM_STATUS_EN`).
- `out_uflow`  out  1  shift was clamped by the exponent (only with `NORM_STATUS_EN`).

## Operation
- **Stage 1 (S1)**
  - Registers `in_mant` and `in_exp`.
  - Registers the count `lz` in the range 0..16 from a combinational `lza_16` instance on `in_mant`.
- **Stage 2 (S2):** computes the result from the S1 registers and registers it as the output.
  - Mantissa zero (`lz` = 16): `out_mant` = 0, `out_exp` = 0, `out_zero` = 1, `out_uflow` = 0.
  - Else if `exp` > `lz`: shift = `lz`, `out_exp` = `exp` − `lz`, `out_uflow` = 0.
  - Else (`exp` ≤ `lz`): shift = `exp`, `out_exp` = 0, `out_uflow` = 1. With `exp` = 0, the mantissa passes through unshifted.
  - `out_mant` = mantissa << shift. Zeros fill from the LSB and no bits are lost, because shift ≤ `lz`.
- **Exponent arithmetic:** 8-bit unsigned. `lz` is zero-extended to 8 bits, and the comparison precedes the subtraction, so no wrap-around is possible.
- **Handshake**
  - A transfer occurs when valid and ready are both high on the same edge.
  - `out_valid` is driven by S2; the S1 valid bit is internal.
  - S2 loads when it is empty or `out_ready` = 1.
  - S1 loads when it is empty or S1 is moving into S2.
  - `in_ready` = !S1 valid || S1 advancing. It is combinational from `out_ready` through the stage-advance logic.
- **Stall:** while `out_valid` && !`out_ready`, all S2 outputs hold stable. S1 fills, then `in_ready` drops.
- **Ordering:** results emerge strictly in input order. No operand is dropped or duplicated.

## Timing
- **Latency:** 2 cycles. An operand accepted at edge N shows `out_valid` = 1 after edge N+1 (readable at edge N+2) when there is no stall.
- **Throughput:** 1 operand per cycle while `out_ready` = 1.
- **Reset values:** `out_valid` = 0, `out_mant` = 0, `out_exp` = 0, `out_zero` = 0, `out_uflow` = 0, S1 valid = 0. `in_ready` reads 1 while in reset.
- **Reset mid-operation:** in-flight operands are discarded. There is no output pulse on reset release.
- **Simultaneous accept and emit:** a full pipeline with `out_ready` = 1 and `in_valid` = 1 accepts and emits in the same cycle with no bubble.
- Data registers load only on their stage's enable. Output data changes only when a new result loads into S2.

## Configuration
- **`NORM_STATUS_EN` defined:** the `out_zero` and `out_uflow` ports and their S2 registers exist.
- **`NORM_STATUS_EN` undefined:**
  - Those ports and registers are absent.
  - Datapath and handshake behaviour are otherwise identical.
  - A zero mantissa still yields `out_mant` = 0 and `out_exp` = 0.

## Structure
- **Shared FP package:** `MANT_W` = 16, `EXP_W` = 8, `LZ_W` = 5.
- **Sub-module:** one `lza_16` instance in stage 1.
- The shifter and exponent logic are inline in S2. A 4-level barrel shift, with a separate zero case, is adequate.

## Test plan
- `in_mant` = 0x0123, `in_exp` = 20 → `out_mant` = 0x9180, `out_exp` = 13, `uflow` = 0, `zero` = 0, 2 cycles after accept.
- `in_mant` = 0x8000, `in_exp` = 1 → `out_mant` = 0x8000, `out_exp` = 1, `uflow` = 0 (no shift).
- `in_mant` = 0x0010, `in_exp` = 4 → `out_mant` = 0x0100, `out_exp` = 0, `uflow` = 1. Also `in_exp` = 0 → 0x0010, `out_exp` = 0, `uflow` = 1.
- `in_mant` = 0x0000, `in_exp` = 50 → `out_mant` = 0, `out_exp` = 0, `zero` = 1.
- Back-pressure:
  - Stimulus: stream 0x0001/16, 0x0002/16, 0x0004/16 with `out_ready` held low for 4 cycles.
  - Response: `in_ready` drops after two accepts and outputs stay frozen.
  - After release: 0x8000/1, 0x8000/2, 0x8000/3 in order, back-to-back.
- Reset:
  - Stimulus: assert `rst_n` = 0 with both stages full.
  - Response: `out_valid` goes 0 immediately (asynchronously), and no stale result appears after release.
  - Recovery: the first new operand emerges with 2-cycle latency.

Source files
------------

// File: rtl/norm_shift_16_pkg.sv
// Shared FP datapath widths and the stage-1 payload type for the 16-bit normalizer.
package norm_shift_16_pkg;
   localparam int MANT_W = 16;
   localparam int EXP_W  = 8;
   localparam int LZ_W   = 5;

   typedef struct packed {
      logic [MANT_W-1:0] mant;
      logic [EXP_W-1:0]  exp;
      logic [LZ_W-1:0]   lz;
   } s1_payload_t;

   function automatic logic [EXP_W-1:0] lz_to_exp(input logic [LZ_W-1:0] lz);
      return {{(EXP_W-LZ_W){1'b0}}, lz};
   endfunction
endpackage

// File: rtl/lza_16.sv
// Combinational leading-zero counter for a 16-bit mantissa; returns 16 for an all-zero input.
module lza_16
   import norm_shift_16_pkg::*;
(
   input  logic [MANT_W-1:0] mant_i,
   output logic [LZ_W-1:0]   lz_o
);
   always_comb begin
      lz_o = LZ_W'(MANT_W);
      // ascending scan, so the most significant set bit is the last to write
      for (int i = 0; i < MANT_W; i++) begin
         if (mant_i[i]) lz_o = LZ_W'(MANT_W - 1 - i);
      end
   end
endmodule

// File: rtl/norm_shift_16.sv
// Two-stage mantissa normalizer with valid/ready on both sides.
// Optional status outputs out_zero/out_uflow exist only when NORM_STATUS_EN is defined.
module norm_shift_16
   import norm_shift_16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] in_mant,
   input  logic [EXP_W-1:0]  in_exp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] out_mant,
   output logic [EXP_W-1:0]  out_exp
`ifdef NORM_STATUS_EN
   ,
   output logic              out_zero,
   output logic              out_uflow
`endif
);
   logic              s1_valid_q, s1_valid_d;
   s1_payload_t       s1_q;
   logic [LZ_W-1:0]   lz;
   logic              s2_en, s1_load, s2_load;
   logic              out_valid_q, out_valid_d;
   logic [MANT_W-1:0] mant_q, mant_d, sh_m;
   logic [EXP_W-1:0]  exp_q, exp_d, lz_ext;
   logic [3:0]        sh;
   logic              is_zero;

   lza_16 u_lza (
      .mant_i (in_mant),
      .lz_o   (lz)
   );

   assign s2_en       = !out_valid_q || out_ready;
   assign in_ready    = !s1_valid_q || s2_en;
   assign s1_load     = in_valid && in_ready;
   assign s2_load     = s2_en && s1_valid_q;
   assign s1_valid_d  = in_ready ? in_valid : s1_valid_q;
   assign out_valid_d = s2_en ? s1_valid_q : out_valid_q;

   assign lz_ext  = lz_to_exp(s1_q.lz);
   assign is_zero = (s1_q.lz == LZ_W'(MANT_W));

   // comparison before subtraction keeps the exponent from wrapping
   always_comb begin
      sh    = '0;
      exp_d = '0;
      if (is_zero) begin
         exp_d = '0;
      end else if (s1_q.exp > lz_ext) begin
         sh    = s1_q.lz[3:0];
         exp_d = s1_q.exp - lz_ext;
      end else begin
         sh    = s1_q.exp[3:0];
      end
      sh_m = s1_q.mant;
      if (sh[3]) sh_m = sh_m << 8;
      if (sh[2]) sh_m = sh_m << 4;
      if (sh[1]) sh_m = sh_m << 2;
      if (sh[0]) sh_m = sh_m << 1;
      mant_d = is_zero ? '0 : sh_m;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         mant_q      <= '0;
         exp_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         if (s1_load) s1_q <= '{mant: in_mant, exp: in_exp, lz: lz};
         if (s2_load) begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
         end
      end
   end

`ifdef NORM_STATUS_EN
   logic zero_q, uflow_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q  <= 1'b0;
         uflow_q <= 1'b0;
      end else if (s2_load) begin
         zero_q  <= is_zero;
         uflow_q <= !is_zero && (s1_q.exp <= lz_ext);
      end
   end
   assign out_zero  = zero_q;
   assign out_uflow = uflow_q;
`endif

   assign out_valid = out_valid_q;
   assign out_mant  = mant_q;
   assign out_exp   = exp_q;
endmodule

// File: tb/tb_norm_shift_16.sv
// Directed bench for norm_shift_16: vector table plus back-pressure and reset sequences.
module tb_norm_shift_16;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_mant, out_mant;
   logic [7:0]  in_exp, out_exp;
`ifdef NORM_STATUS_EN
   logic        out_zero, out_uflow;
`endif

   int errors = 0;
   int checks = 0;

   norm_shift_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mant   (in_mant),
      .in_exp    (in_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mant  (out_mant),
      .out_exp   (out_exp)
`ifdef NORM_STATUS_EN
      ,
      .out_zero  (out_zero),
      .out_uflow (out_uflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] mant;
      logic [7:0]  exp;
      logic [15:0] x_mant;
      logic [7:0]  x_exp;
      logic        x_zero;
      logic        x_uflow;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic chk_out(input string name, input logic [15:0] m, input logic [7:0] e,
                          input logic z, input logic u);
      chk({name, " valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, " mant"}, {16'd0, out_mant}, {16'd0, m});
      chk({name, " exp"}, {24'd0, out_exp}, {24'd0, e});
`ifdef NORM_STATUS_EN
      chk({name, " zero"}, {31'd0, out_zero}, {31'd0, z});
      chk({name, " uflow"}, {31'd0, out_uflow}, {31'd0, u});
`else
      if (z || u) begin end
`endif
   endtask

   // single operand with out_ready high: accept at edge N, visible after N+1
   task automatic run_vec(input vec_t v, input int idx);
      string n;
      n = $sformatf("vec%0d", idx);
      @(negedge clk);
      in_valid = 1'b1; in_mant = v.mant; in_exp = v.exp;
      chk({n, " in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({n, " lat1 valid"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk_out(n, v.x_mant, v.x_exp, v.x_zero, v.x_uflow);
      @(posedge clk);
   endtask

   initial begin
      vecs[0]  = '{16'h0123, 8'd20,  16'h9180, 8'd13,  1'b0, 1'b0};
      vecs[1]  = '{16'h8000, 8'd1,   16'h8000, 8'd1,   1'b0, 1'b0};
      vecs[2]  = '{16'h0010, 8'd4,   16'h0100, 8'd0,   1'b0, 1'b1};
      vecs[3]  = '{16'h0010, 8'd0,   16'h0010, 8'd0,   1'b0, 1'b1};
      vecs[4]  = '{16'h0000, 8'd50,  16'h0000, 8'd0,   1'b1, 1'b0};
      vecs[5]  = '{16'h0010, 8'd11,  16'h8000, 8'd0,   1'b0, 1'b1};
      vecs[6]  = '{16'h0010, 8'd12,  16'h8000, 8'd1,   1'b0, 1'b0};
      vecs[7]  = '{16'h0001, 8'd255, 16'h8000, 8'd240, 1'b0, 1'b0};
      vecs[8]  = '{16'hFFFF, 8'd0,   16'hFFFF, 8'd0,   1'b0, 1'b1};
      vecs[9]  = '{16'h4000, 8'h80,  16'h8000, 8'h7F,  1'b0, 1'b0};
      vecs[10] = '{16'h0003, 8'd3,   16'h0018, 8'd0,   1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
      #12;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_mant", {16'd0, out_mant}, 32'd0);
      chk("reset out_exp", {24'd0, out_exp}, 32'd0);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef NORM_STATUS_EN
      chk("reset out_zero", {31'd0, out_zero}, 32'd0);
      chk("reset out_uflow", {31'd0, out_uflow}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // back-pressure: three operands, output stalled for 4 cycles
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_mant = 16'h0001; in_exp = 8'd16;
      chk("bp accept A ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_mant = 16'h0002; in_exp = 8'd16;
      chk("bp accept B ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_mant = 16'h0004; in_exp = 8'd16;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("bp stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
         chk_out($sformatf("bp stall%0d", c), 16'h8000, 8'd1, 1'b0, 1'b0);
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
      chk_out("bp out A", 16'h8000, 8'd1, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("bp out B", 16'h8000, 8'd2, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk_out("bp out C", 16'h8000, 8'd3, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("bp drained", {31'd0, out_valid}, 32'd0);

      // reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; in_mant = 16'h0123; in_exp = 8'd20;
      @(posedge clk);
      @(negedge clk);
      in_mant = 16'h0010; in_exp = 8'd4;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst pre out_valid", {31'd0, out_valid}, 32'd1);
      chk("rst pre in_ready", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst async out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst async in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst async out_mant", {16'd0, out_mant}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst no stale %0d", c), {31'd0, out_valid}, 32'd0);
      end
      run_vec(vecs[0], 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
